// File: rtl/kv_req_arbiter.sv
// Round-robin arbiter sharing one key-value DB lookup port between two requesters.
// Optional statistics counters are built only when KV_ARB_STATS_EN is defined.
module kv_req_arbiter #(
    parameter int unsigned KEY_SIZE    = 96,
    parameter int unsigned FLAG_SIZE   = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 clk156,
    input  logic                 eth_rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [KEY_SIZE-1:0]  req0_key,
    input  logic [FLAG_SIZE-1:0] req0_flag,
    output logic                 rsp0_valid,
    output logic [FLAG_SIZE-1:0] rsp0_flag,
    output logic                 rsp0_timeout,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [KEY_SIZE-1:0]  req1_key,
    input  logic [FLAG_SIZE-1:0] req1_flag,
    output logic                 rsp1_valid,
    output logic [FLAG_SIZE-1:0] rsp1_flag,
    output logic                 rsp1_timeout,

    output logic [KEY_SIZE-1:0]  db_in_key,
    output logic [FLAG_SIZE-1:0] db_in_flag,
    output logic                 db_in_valid,
    input  logic                 db_out_valid,
    input  logic [FLAG_SIZE-1:0] db_out_flag,

    output logic                 busy,
    output logic [15:0]          stat_grant0,
    output logic [15:0]          stat_grant1,
    output logic [15:0]          stat_timeout,
    output logic [15:0]          stat_late
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYC - 1);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_grant_q, last_grant_d;
    logic [15:0]          timer_q, timer_d;
    logic                 done, done_to;

    logic                 hold0_valid_q, hold1_valid_q;
    logic [KEY_SIZE-1:0]  hold0_key_q, hold1_key_q;
    logic [FLAG_SIZE-1:0] hold0_flag_q, hold1_flag_q;

    logic                 issue;

    assign issue      = (state_q == StIssue);
    assign busy       = (state_q != StIdle);
    assign req0_ready = !hold0_valid_q;
    assign req1_ready = !hold1_valid_q;

    // Holding registers: capture when empty, clear on the owner's ISSUE cycle.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            hold0_valid_q <= 1'b0;
            hold1_valid_q <= 1'b0;
            hold0_key_q   <= '0;
            hold1_key_q   <= '0;
            hold0_flag_q  <= '0;
            hold1_flag_q  <= '0;
        end else begin
            if (req0_valid && !hold0_valid_q) begin
                hold0_valid_q <= 1'b1;
                hold0_key_q   <= req0_key;
                hold0_flag_q  <= req0_flag;
            end else if (issue && !owner_q) begin
                hold0_valid_q <= 1'b0;
            end
            if (req1_valid && !hold1_valid_q) begin
                hold1_valid_q <= 1'b1;
                hold1_key_q   <= req1_key;
                hold1_flag_q  <= req1_flag;
            end else if (issue && owner_q) begin
                hold1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        done         = 1'b0;
        done_to      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hold0_valid_q || hold1_valid_q) begin
                    if (hold0_valid_q && hold1_valid_q) begin
                        owner_d = !last_grant_q;
                    end else begin
                        owner_d = hold1_valid_q;
                    end
                    last_grant_d = owner_d;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 16'd1;
                // A reply in the expiry cycle takes precedence over the timeout.
                if (db_out_valid) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (timer_q == TimerLast) begin
                    done    = 1'b1;
                    done_to = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        db_in_valid = issue;
        db_in_key   = '0;
        db_in_flag  = '0;
        if (issue) begin
            db_in_key  = owner_q ? hold1_key_q  : hold0_key_q;
            db_in_flag = owner_q ? hold1_flag_q : hold0_flag_q;
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            rsp0_valid   <= 1'b0;
            rsp0_flag    <= '0;
            rsp0_timeout <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_flag    <= '0;
            rsp1_timeout <= 1'b0;
        end else begin
            rsp0_valid   <= done && !owner_q;
            rsp0_flag    <= (done && !done_to && !owner_q) ? db_out_flag : '0;
            rsp0_timeout <= done && done_to && !owner_q;
            rsp1_valid   <= done && owner_q;
            rsp1_flag    <= (done && !done_to && owner_q) ? db_out_flag : '0;
            rsp1_timeout <= done && done_to && owner_q;
        end
    end

`ifdef KV_ARB_STATS_EN
    logic [15:0] grant0_q, grant1_q, timeout_q, late_q;
    logic        late;

    // Replies outside WAIT belong to no outstanding request.
    assign late = db_out_valid && (state_q != StWait);

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            grant0_q  <= '0;
            grant1_q  <= '0;
            timeout_q <= '0;
            late_q    <= '0;
        end else begin
            if (issue && !owner_q && grant0_q != 16'hFFFF) grant0_q <= grant0_q + 16'd1;
            if (issue && owner_q && grant1_q != 16'hFFFF)  grant1_q <= grant1_q + 16'd1;
            if (done_to && timeout_q != 16'hFFFF)          timeout_q <= timeout_q + 16'd1;
            if (late && late_q != 16'hFFFF)                late_q <= late_q + 16'd1;
        end
    end

    assign stat_grant0  = grant0_q;
    assign stat_grant1  = grant1_q;
    assign stat_timeout = timeout_q;
    assign stat_late    = late_q;
`else
    assign stat_grant0  = 16'd0;
    assign stat_grant1  = 16'd0;
    assign stat_timeout = 16'd0;
    assign stat_late    = 16'd0;
`endif

endmodule

// File: tb/tb_kv_req_arbiter.sv
// Randomized scoreboard bench for kv_req_arbiter with a transaction-level arbitration model
// and a DB responder that plans replies, timeouts and late replies.
module tb_kv_req_arbiter;

    localparam int unsigned KS = 96;
    localparam int unsigned FS = 4;
    localparam int unsigned TO = 4;
`ifdef KV_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk156 = 1'b0;
    logic          eth_rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [KS-1:0] req0_key, req1_key, db_in_key;
    logic [FS-1:0] req0_flag, req1_flag, rsp0_flag, rsp1_flag, db_in_flag, db_out_flag;
    logic          rsp0_valid, rsp1_valid, rsp0_timeout, rsp1_timeout;
    logic          db_in_valid, db_out_valid, busy;
    logic [15:0]   stat_grant0, stat_grant1, stat_timeout, stat_late;

    kv_req_arbiter #(.KEY_SIZE(KS), .FLAG_SIZE(FS), .TIMEOUT_CYC(TO)) dut (
        .clk156(clk156), .eth_rst(eth_rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key),
        .req0_flag(req0_flag), .rsp0_valid(rsp0_valid), .rsp0_flag(rsp0_flag),
        .rsp0_timeout(rsp0_timeout),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key),
        .req1_flag(req1_flag), .rsp1_valid(rsp1_valid), .rsp1_flag(rsp1_flag),
        .rsp1_timeout(rsp1_timeout),
        .db_in_key(db_in_key), .db_in_flag(db_in_flag), .db_in_valid(db_in_valid),
        .db_out_valid(db_out_valid), .db_out_flag(db_out_flag), .busy(busy),
        .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
        .stat_timeout(stat_timeout), .stat_late(stat_late)
    );

    always #5 clk156 = ~clk156;

    int cyc = 0;
    always @(posedge clk156) cyc <= cyc + 1;

    typedef struct { int cyc; logic [FS-1:0] flag; logic to; } exp_t;
    typedef struct { int cyc; logic [FS-1:0] flag; logic late; } plan_t;

    exp_t  exp_q0[$];
    exp_t  exp_q1[$];
    plan_t sched[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: one unissued request per port, tagged with its accept cycle.
    logic          pend_v[2];
    int            pend_c[2];
    logic [KS-1:0] pend_k[2];
    logic [FS-1:0] pend_f[2];
    logic          last_g;
    int            m_grant[2];
    int            m_to, m_late;
    logic          cur_late = 1'b0;
    logic          directed = 1'b0;
    logic          dir_issued = 1'b0;
    logic          post_rst = 1'b0;
    logic          end_chk = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    endtask

    // Model: readiness, arbitration order, issued key/flag, reply planning, statistics.
    always @(negedge clk156) begin
        logic rdy0, rdy1, c0, c1, p;
        int   d;
        logic [FS-1:0] f;
        if (eth_rst) begin
            pend_v[0] = 1'b0; pend_v[1] = 1'b0;
            exp_q0.delete(); exp_q1.delete();
            last_g = 1'b1;
            m_grant[0] = 0; m_grant[1] = 0; m_to = 0; m_late = 0;
            post_rst = 1'b1;
        end else begin
            if (post_rst && directed) chk("busy_after_reset", busy, 0);
            post_rst = 1'b0;
            rdy0 = !pend_v[0];
            rdy1 = !pend_v[1];
            chk("req0_ready", req0_ready, rdy0);
            chk("req1_ready", req1_ready, rdy1);
            if (db_in_valid) begin
                c0 = pend_v[0] && (pend_c[0] <= cyc - 2);
                c1 = pend_v[1] && (pend_c[1] <= cyc - 2);
                if (!c0 && !c1) begin
                    chk("spurious_issue", 1, 0);
                end else begin
                    p = (c0 && c1) ? !last_g : c1;
                    last_g = p;
                    chk("issue_key", db_in_key, pend_k[p]);
                    chk("issue_flag", db_in_flag, pend_f[p]);
                    pend_v[p] = 1'b0;
                    m_grant[p]++;
                    if (directed) begin
                        dir_issued = 1'b1;
                        sched.push_back('{cyc: cyc + 3, flag: 4'h5, late: 1'b1});
                    end else begin
                        d = $urandom_range(1, TO + 2);
                        f = FS'($urandom);
                        if (d <= TO) begin
                            sched.push_back('{cyc: cyc + d, flag: f, late: 1'b0});
                            if (p) exp_q1.push_back('{cyc: cyc + d + 1, flag: f, to: 1'b0});
                            else   exp_q0.push_back('{cyc: cyc + d + 1, flag: f, to: 1'b0});
                        end else begin
                            sched.push_back('{cyc: cyc + d, flag: f, late: 1'b1});
                            if (p) exp_q1.push_back('{cyc: cyc + TO + 1, flag: '0, to: 1'b1});
                            else   exp_q0.push_back('{cyc: cyc + TO + 1, flag: '0, to: 1'b1});
                            m_to++;
                        end
                    end
                end
            end else begin
                chk("db_in_idle_zero", {db_in_key, db_in_flag}, 0);
            end
            if (db_out_valid && cur_late) m_late++;
            if (req0_valid && rdy0) begin
                pend_v[0] = 1'b1; pend_c[0] = cyc; pend_k[0] = req0_key; pend_f[0] = req0_flag;
            end
            if (req1_valid && rdy1) begin
                pend_v[1] = 1'b1; pend_c[1] = cyc; pend_k[1] = req1_key; pend_f[1] = req1_flag;
            end
            if (end_chk) begin
                chk("drained_pending", {pend_v[0], pend_v[1]}, 0);
                chk("drained_rsp", exp_q0.size() + exp_q1.size(), 0);
                chk("stat_grant0", stat_grant0, STATS ? m_grant[0] : 0);
                chk("stat_grant1", stat_grant1, STATS ? m_grant[1] : 0);
                chk("stat_timeout", stat_timeout, STATS ? m_to : 0);
                chk("stat_late", stat_late, STATS ? m_late : 0);
                if (directed) chk("directed_issue_seen", dir_issued, 1);
            end
        end
    end

    task automatic mon_port(input bit p, input logic v, input logic [FS-1:0] f, input logic t);
        exp_t e;
        int   sz;
        sz = p ? exp_q1.size() : exp_q0.size();
        if (v) begin
            if (sz == 0) begin
                chk(p ? "rsp1_unexpected" : "rsp0_unexpected", 1, 0);
            end else begin
                e = p ? exp_q1.pop_front() : exp_q0.pop_front();
                chk(p ? "rsp1_cycle" : "rsp0_cycle", cyc, e.cyc);
                chk(p ? "rsp1_flag" : "rsp0_flag", f, e.flag);
                chk(p ? "rsp1_timeout" : "rsp0_timeout", t, e.to);
            end
        end else begin
            chk(p ? "rsp1_idle_zero" : "rsp0_idle_zero", {f, t}, 0);
            if (sz != 0) begin
                e = p ? exp_q1[0] : exp_q0[0];
                if (e.cyc < cyc) begin
                    chk(p ? "rsp1_missing" : "rsp0_missing", 0, 1);
                    if (p) void'(exp_q1.pop_front());
                    else   void'(exp_q0.pop_front());
                end
            end
        end
    endtask

    // Response monitor: pops the scoreboard whenever a reply strobe appears.
    always @(negedge clk156) begin
        if (!eth_rst) begin
            mon_port(1'b0, rsp0_valid, rsp0_flag, rsp0_timeout);
            mon_port(1'b1, rsp1_valid, rsp1_flag, rsp1_timeout);
        end
    end

    task automatic tick();
        plan_t pl;
        @(posedge clk156);
        #1;
        db_out_valid = 1'b0;
        db_out_flag  = '0;
        cur_late     = 1'b0;
        if (sched.size() != 0 && sched[0].cyc == cyc) begin
            pl = sched.pop_front();
            db_out_valid = 1'b1;
            db_out_flag  = pl.flag;
            cur_late     = pl.late;
        end
    endtask

    initial begin
        eth_rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_key = '0; req1_key = '0; req0_flag = '0; req1_flag = '0;
        db_out_valid = 1'b0; db_out_flag = '0;
        repeat (3) tick();
        eth_rst = 1'b0;
        req0_valid = 1'b1;
        req0_key   = 96'h0A000001_0A000002_3039_0000;
        req0_flag  = 4'b0011;
        for (int i = 0; i < 1500; i++) begin
            tick();
            req0_valid = ($urandom_range(0, 2) == 0);
            req1_valid = ($urandom_range(0, 2) == 0);
            req0_key   = {$urandom, $urandom, $urandom};
            req1_key   = {$urandom, $urandom, $urandom};
            req0_flag  = FS'($urandom);
            req1_flag  = FS'($urandom);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (30) tick();
        end_chk = 1'b1;
        tick();
        end_chk = 1'b0;

        // Reset while a request is waiting on the DB; its reply then arrives late.
        directed   = 1'b1;
        req0_valid = 1'b1;
        req0_key   = 96'h0A000001_0A000002_3039_0000;
        req0_flag  = 4'b0011;
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < 10 && !dir_issued; k++) tick();
        eth_rst = 1'b1;
        tick();
        eth_rst = 1'b0;
        repeat (8) tick();
        end_chk = 1'b1;
        tick();
        end_chk = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
